// File: rtl/nms_datapath_if.sv
// Bus bundle between the NMS sequencer, score memory, keypoint writer and the
// NMS score datapath.
//   refAddr   : current score-memory write address (sequencer)
//   adjNumber : neighbour index 0..8 issued this cycle, other = idle
//   regAddr   : register index 0..8 whose score arrives this cycle, other = none
//   readen    : one-cycle evaluate strobe
//   memAddr / memRen / memData : score-memory read port (data one cycle after ren)
//   nmsValid / isMax / nmsAddr / winErr : keypoint result
// slave = datapath view, master = sequencer/memory/writer view.
interface nms_datapath_if #(parameter int SCORE_W = 8);
  logic [14:0]        refAddr;
  logic [3:0]         adjNumber;
  logic [3:0]         regAddr;
  logic               readen;
  logic [14:0]        memAddr;
  logic               memRen;
  logic [SCORE_W-1:0] memData;
  logic               nmsValid;
  logic               isMax;
  logic [14:0]        nmsAddr;
  logic               winErr;

  modport slave (
    input  refAddr, adjNumber, regAddr, readen, memData,
    output memAddr, memRen, nmsValid, isMax, nmsAddr, winErr
  );

  modport master (
    output refAddr, adjNumber, regAddr, readen, memData,
    input  memAddr, memRen, nmsValid, isMax, nmsAddr, winErr
  );
endinterface

// File: rtl/nms_datapath.sv
// NMS score datapath: fetches the 3x3 FAST score window around a candidate
// centre, holds it in a 9-entry register file and reports whether the centre
// score is a strict local maximum.
// Ports:
//   clock  : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : nms_datapath_if slave (sequencer inputs, memory port, result)
module nms_datapath #(
  parameter int IMG_WIDTH  = 300,
  parameter int CENTER_LAG = 302,
  parameter int SCORE_W    = 8
) (
  input  logic          clock,
  input  logic          nReset,
  nms_datapath_if.slave bus
);
  localparam logic [14:0] ROW = 15'(IMG_WIDTH);
  localparam logic [14:0] LAG = 15'(CENTER_LAG);

  logic [14:0]              centre_addr, base, row_off, col_off;
  logic [8:0][SCORE_W-1:0]  score, score_nxt;
  logic [8:0]               mask, load, mask_nxt, gt;
  logic                     adj_ok, first, win_full, is_max_nxt;

  assign adj_ok = (bus.adjNumber <= 4'd8);
  assign first  = (bus.adjNumber == 4'd0);
  // Index 0 starts a new window, so its address comes straight from refAddr;
  // later indices use the latched centre so refAddr may move freely.
  assign base   = first ? (bus.refAddr - LAG) : centre_addr;

  always_comb begin
    row_off = '0;
    col_off = '0;
    case (bus.adjNumber)
      4'd0, 4'd1, 4'd2: row_off = 15'd0 - ROW;
      4'd6, 4'd7, 4'd8: row_off = ROW;
      default:          row_off = '0;
    endcase
    case (bus.adjNumber)
      4'd0, 4'd3, 4'd6: col_off = 15'h7FFF;
      4'd2, 4'd5, 4'd8: col_off = 15'd1;
      default:          col_off = '0;
    endcase
  end

  // Same-cycle load is folded into the evaluated window (load-then-compare).
  genvar k;
  generate
    for (k = 0; k < 9; k++) begin : g_ent
      assign load[k]      = (bus.regAddr == 4'(k));
      assign score_nxt[k] = load[k] ? bus.memData : score[k];
      assign mask_nxt[k]  = mask[k] | load[k];
      if (k == 4) begin : g_ctr
        assign gt[k] = 1'b1;
      end else begin : g_nbr
        assign gt[k] = (score_nxt[4] > score_nxt[k]);
      end
    end
  endgenerate

  assign win_full   = &mask_nxt;
  assign is_max_nxt = win_full && (score_nxt[4] != '0) && (&gt);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      bus.memAddr  <= '0;
      bus.memRen   <= 1'b0;
      bus.nmsValid <= 1'b0;
      bus.isMax    <= 1'b0;
      bus.nmsAddr  <= '0;
      bus.winErr   <= 1'b0;
      centre_addr  <= '0;
      score        <= '0;
      mask         <= '0;
    end else begin
      bus.memRen <= adj_ok;
      if (adj_ok) bus.memAddr <= base + row_off + col_off;
      if (first)  centre_addr <= base;
      score <= score_nxt;
      // A window start drops old mask bits but keeps a load landing this cycle.
      mask  <= (first ? 9'h000 : mask) | load;
      bus.nmsValid <= bus.readen;
      // Evaluation reports on the window being closed, so it wins over the
      // winErr clear of a window starting in the same cycle.
      if (bus.readen) begin
        bus.isMax   <= is_max_nxt;
        bus.nmsAddr <= centre_addr;
        bus.winErr  <= ~win_full;
      end else if (first) begin
        bus.winErr  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nms_datapath.sv
module tb_nms_datapath;
  logic clock = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  nms_datapath_if #(.SCORE_W(8)) bus();

  nms_datapath #(.IMG_WIDTH(300), .CENTER_LAG(302), .SCORE_W(8)) dut (
    .clock(clock),
    .nReset(nReset),
    .bus(bus)
  );

  // Score memory model (registered read) and regAddr = adjNumber delayed 2.
  logic [7:0] mem [0:32767];
  logic [7:0] rd_q   = 8'd0;
  logic [3:0] adj_d1 = 4'hF;
  logic [3:0] adj_d2 = 4'hF;
  always @(posedge clock) begin
    if (bus.memRen) rd_q <= mem[bus.memAddr];
    adj_d1 <= bus.adjNumber;
    adj_d2 <= adj_d1;
  end
  assign bus.memData = rd_q;
  assign bus.regAddr = adj_d2;

  int checks = 0;
  int failures = 0;
  logic [14:0] exp_addr [$];
  logic [16:0] exp_res [$];   // {isMax, nmsAddr, winErr}
  logic [14:0] ea;
  logic [16:0] er;

  // Monitor: pops an expectation whenever the DUT presents a read or a result.
  always @(negedge clock) begin
    if (nReset) begin
      if (bus.memRen) begin
        checks++;
        if (exp_addr.size() == 0) begin
          failures++;
          $display("FAIL memaddr_unexpected got=%0d", bus.memAddr);
        end else begin
          ea = exp_addr.pop_front();
          if (bus.memAddr !== ea) begin
            failures++;
            $display("FAIL memaddr got=%0d exp=%0d", bus.memAddr, ea);
          end
        end
      end
      if (bus.nmsValid) begin
        checks++;
        if (exp_res.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected isMax=%0b addr=%0d err=%0b",
                   bus.isMax, bus.nmsAddr, bus.winErr);
        end else begin
          er = exp_res.pop_front();
          if ({bus.isMax, bus.nmsAddr, bus.winErr} !== er) begin
            failures++;
            $display("FAIL result got isMax=%0b addr=%0d err=%0b exp isMax=%0b addr=%0d err=%0b",
                     bus.isMax, bus.nmsAddr, bus.winErr, er[16], er[15:1], er[0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_memAddr"},  32'(bus.memAddr),  0);
    chk({tag, "_memRen"},   32'(bus.memRen),   0);
    chk({tag, "_nmsValid"}, 32'(bus.nmsValid), 0);
    chk({tag, "_isMax"},    32'(bus.isMax),    0);
    chk({tag, "_nmsAddr"},  32'(bus.nmsAddr),  0);
    chk({tag, "_winErr"},   32'(bus.winErr),   0);
  endtask

  // s[k] is the score for window index k (row-major, 4 = centre).
  task automatic set_win(input logic [14:0] a0, input logic [8:0][7:0] s);
    for (int k = 0; k < 9; k++) mem[a0 + 15'((k / 3) * 300 + (k % 3))] = s[k];
  endtask

  // Issues adjNumber 0..8, then readen 'lag' cycles after adjNumber=8.
  // a0 is the hand-computed read address for index 0.
  task automatic window(input logic [14:0] ra, input logic [14:0] a0, input int lag,
                        input logic emax, input logic [14:0] eaddr, input logic eerr);
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      bus.adjNumber = 4'(k);
      bus.refAddr   = (k == 0) ? ra : 15'($urandom);
      exp_addr.push_back(a0 + 15'((k / 3) * 300 + (k % 3)));
    end
    for (int i = 1; i <= lag; i++) begin
      @(posedge clock); #1;
      bus.adjNumber = 4'hF;
      if (i == lag) begin
        bus.readen = 1'b1;
        exp_res.push_back({emax, eaddr, eerr});
      end
    end
    @(posedge clock); #1;
    bus.readen = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'd0;
    bus.refAddr   = '0;
    bus.adjNumber = 4'hF;
    bus.readen    = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    nReset = 1'b1;
    repeat (2) @(posedge clock);

    // Centre 698 at score 50, neighbours 10..40.
    set_win(15'd397, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
    window(15'd1000, 15'd397, 3, 1'b1, 15'd698, 1'b0);
    // Tie on index 7 suppresses the centre.
    mem[998] = 8'd50;
    window(15'd1000, 15'd397, 3, 1'b0, 15'd698, 1'b0);
    // All-zero window: zero centre is never a keypoint.
    set_win(15'd397, '0);
    window(15'd1000, 15'd397, 3, 1'b0, 15'd698, 1'b0);
    // Address wrap: 100-302 -> 32566, index 0 at 32265, bottom row wraps to 97..99.
    set_win(15'd32265, {8'd1, 8'd6, 8'd6, 8'd5, 8'd7, 8'd4, 8'd3, 8'd2, 8'd1});
    window(15'd100, 15'd32265, 3, 1'b1, 15'd32566, 1'b0);
    // readen with the regAddr=8 load: 60 beats centre 50, then 45 does not.
    set_win(15'd1397, {8'd60, 8'd20, 8'd30, 8'd40, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
    window(15'd2000, 15'd1397, 2, 1'b0, 15'd1698, 1'b0);
    mem[1999] = 8'd45;
    window(15'd2000, 15'd1397, 2, 1'b1, 15'd1698, 1'b0);

    // Reset mid-window, right after the regAddr=3 load.
    set_win(15'd397, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      bus.adjNumber = 4'(k);
      bus.refAddr   = (k == 0) ? 15'd1000 : 15'($urandom);
      if (k < 5) exp_addr.push_back(15'd397 + 15'((k / 3) * 300 + (k % 3)));
    end
    @(posedge clock); #1;
    nReset = 1'b0;
    bus.adjNumber = 4'hF;
    @(negedge clock);
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clock);
    #1 nReset = 1'b1;
    repeat (3) @(posedge clock);
    #1 bus.readen = 1'b1;
    exp_res.push_back({1'b0, 15'd0, 1'b1});
    @(posedge clock); #1;
    bus.readen = 1'b0;
    repeat (4) @(posedge clock);

    @(negedge clock);
    chk("addr_queue_empty", 32'(exp_addr.size()), 0);
    chk("result_queue_empty", 32'(exp_res.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
